nonce_uart_tx: RTL



---
 rtl/nonce_uart_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/nonce_uart_tx.sv
// Drains a 32-bit result word to the host as four 8N1 UART frames, MSB byte first.
// Define NONCE_TX_HEADER_EN to prepend a 0xA5 sync frame to every word.
module nonce_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef NONCE_TX_HEADER_EN
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_BYTE = 3'd4;
`else
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_BYTE = 2'd3;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [31:0]        hold_q, hold_d;
  logic               tx_q, tx_d;

  logic               bit_end;
  logic [2:0]         next_bit;
  logic [7:0]         cur_byte;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [IDX_W-1:0] idx);
`ifdef NONCE_TX_HEADER_EN
    case (idx)
      3'd0:    byte_sel = 8'hA5;
      3'd1:    byte_sel = w[31:24];
      3'd2:    byte_sel = w[23:16];
      3'd3:    byte_sel = w[15:8];
      default: byte_sel = w[7:0];
    endcase
`else
    case (idx)
      2'd0:    byte_sel = w[31:24];
      2'd1:    byte_sel = w[23:16];
      2'd2:    byte_sel = w[15:8];
      default: byte_sel = w[7:0];
    endcase
`endif
  endfunction

  assign bit_end    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign next_bit   = bit_idx_q + 3'd1;
  assign cur_byte   = byte_sel(hold_q, byte_idx_q);

  assign word_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;

  // tx_d carries the level of the bit that starts on the coming edge, so tx never glitches
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    hold_d     = hold_q;
    tx_d       = tx_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (word_valid) begin
          state_d    = S_START;
          hold_d     = word_in;
          cnt_d      = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_idx_d = next_bit;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = cur_byte[next_bit];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d    = S_IDLE;
            byte_idx_d = '0;
            tx_d       = 1'b1;
          end else begin
            state_d    = S_START;
            byte_idx_d = byte_idx_q + IDX_W'(1);
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      hold_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
    end
  end

endmodule
